// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA definitions for the instruction encoder.
// Contents:
//   - instruction width and field bit positions
//   - immediate field widths per class (4/4/8/9)
//   - opcode classes, with a classifier function
//   - error-code constants, with a class-to-code helper
//   - the encoder FSM state type
package isa_pkg;

   localparam int unsigned InstrW = 16;

   // Field bit positions inside the 16-bit instruction word
   localparam int unsigned OpMsb   = 15;
   localparam int unsigned OpLsb   = 12;
   localparam int unsigned RaLsb   = 8;
   localparam int unsigned RbLsb   = 4;
   localparam int unsigned RcLsb   = 0;
   localparam int unsigned CondLsb = 9;

   // Immediate field widths per class
   localparam logic [3:0] ImmWCompute  = 4'd4;
   localparam logic [3:0] ImmWMemory   = 4'd4;
   localparam logic [3:0] ImmWLoadByte = 4'd8;
   localparam logic [3:0] ImmWControl  = 4'd9;
   localparam int unsigned ImmWMax     = 9;

   // Error codes follow opcode[15:14] of the class
   localparam logic [1:0] ErrCodeCompute = 2'b00;
   localparam logic [1:0] ErrCodeMemory  = 2'b10;
   localparam logic [1:0] ErrCodeControl = 2'b11;

   typedef enum logic [1:0] {
      ClsCompute,   // 0xxx
      ClsMemory,    // 100x
      ClsLoadByte,  // 101x
      ClsControl    // 11xx
   } instr_class_e;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StDone
   } enc_state_e;

   function automatic instr_class_e op_class(input logic [3:0] op);
      instr_class_e cls;
      if (!op[3]) begin
         cls = ClsCompute;
      end else if (op[2]) begin
         cls = ClsControl;
      end else if (op[1]) begin
         cls = ClsLoadByte;
      end else begin
         cls = ClsMemory;
      end
      return cls;
   endfunction

   // Load-byte shares the memory code: both have opcode[15:14] == 2'b10
   function automatic logic [1:0] class_err_code(input instr_class_e cls);
      logic [1:0] code;
      unique case (cls)
         ClsCompute:  code = ErrCodeCompute;
         ClsMemory:   code = ErrCodeMemory;
         ClsLoadByte: code = ErrCodeMemory;
         ClsControl:  code = ErrCodeControl;
         default:     code = ErrCodeCompute;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/imm_fit_check.sv
// imm_fit_check: combinational immediate narrowing.
// Truncates a 16-bit immediate to width_i bits and reports whether the
// value is representable in that field.
// Ports:
//   imm_i     in  16  full-width immediate
//   width_i   in  4   field width (1..9)
//   signed_i  in  1   1: two's-complement field, 0: unsigned field
//   fits_o    out 1   immediate is representable in the field
//   field_o   out 9   truncated field, zero above width_i
module imm_fit_check
   import isa_pkg::*;
(
   input  logic [InstrW-1:0]  imm_i,
   input  logic [3:0]         width_i,
   input  logic               signed_i,
   output logic               fits_o,
   output logic [ImmWMax-1:0] field_o
);

   logic [InstrW-1:0] trunc;
   logic              msb;

   // Signed fit: every bit above the field equals the field MSB.
   // Unsigned fit: every bit above the field is zero.
   always_comb begin
      trunc  = '0;
      fits_o = 1'b1;
      msb    = imm_i[width_i - 4'd1];
      for (int i = 0; i < int'(InstrW); i++) begin
         if (i < int'(width_i)) begin
            trunc[i] = imm_i[i];
         end else if (signed_i ? (imm_i[i] != msb) : imm_i[i]) begin
            fits_o = 1'b0;
         end
      end
   end

   assign field_o = trunc[ImmWMax-1:0];

   logic unused_trunc;
   assign unused_trunc = ^trunc[InstrW-1:ImmWMax];

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction fields into 16-bit words and
// streams them, with sequential addresses, into an instruction-memory
// write port. Used to load programs before the core leaves reset.
// Build option: define IMM_RANGE_CHECK_EN to reject out-of-range
// immediates (err pulse, err_code); otherwise immediates are truncated.
// Ports:
//   clk_i        in   rising-edge clock
//   rst_i        in   synchronous active-high reset
//   start_i      in   begin a load session (honoured in IDLE or DONE)
//   in_valid_i   in   field bundle valid
//   in_ready_o   out  encoder can accept a bundle
//   in_opcode_i  in   [15:12]
//   in_ra_i      in   [11:8] rd/rt
//   in_rb_i      in   [7:4] rs
//   in_rc_i      in   [3:0] for register-register compute
//   in_cond_i    in   [11:9] branch condition
//   in_imm_i     in   full-width immediate
//   in_use_imm_i in   compute class: low nibble takes imm instead of rc
//   out_valid_o  out  write word valid
//   out_ready_i  in   memory accepts the word
//   out_addr_o   out  write address
//   out_data_o   out  encoded instruction
//   busy_o       out  session in progress
//   done_o       out  session complete
//   err_o        out  one-cycle pulse on a rejected bundle
//   err_code_o   out  class of the last rejected bundle
//   count_o      out  words written this session
module instr_encoder
   import isa_pkg::*;
#(
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        in_opcode_i,
   input  logic [3:0]        in_ra_i,
   input  logic [3:0]        in_rb_i,
   input  logic [3:0]        in_rc_i,
   input  logic [2:0]        in_cond_i,
   input  logic [15:0]       in_imm_i,
   input  logic              in_use_imm_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [ADDR_W-1:0] out_addr_o,
   output logic [15:0]       out_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic [ADDR_W:0]   count_o
);

   localparam logic [ADDR_W:0]   DepthCnt = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

   enc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;        // address of the next word to write
   logic [ADDR_W:0]   count_q, count_d;      // words written (handshaked)
   logic [ADDR_W:0]   acc_q, acc_d;          // words accepted, including the pending one
   logic              out_valid_q, out_valid_d;
   logic [15:0]       out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;

   instr_class_e        cls;
   logic [3:0]          imm_w;
   logic                imm_signed;
   logic                check_en;
   logic                imm_fits;
   logic [ImmWMax-1:0]  imm_field;
   logic [InstrW-1:0]   enc_word;
   logic                hs;
   logic                accept;
   logic                reject;
   logic                wr_accept;

   assign cls = op_class(in_opcode_i);

   // Field width and signedness of the immediate for this class
   always_comb begin
      imm_w      = ImmWCompute;
      imm_signed = 1'b0;
      check_en   = 1'b1;
      unique case (cls)
         ClsCompute: begin
            imm_w      = ImmWCompute;
            imm_signed = 1'b0;
            check_en   = in_use_imm_i;  // register-register form has no immediate
         end
         ClsMemory: begin
            imm_w      = ImmWMemory;
            imm_signed = 1'b1;
         end
         ClsLoadByte: begin
            imm_w      = ImmWLoadByte;
            imm_signed = 1'b1;
         end
         ClsControl: begin
            imm_w      = ImmWControl;
            imm_signed = 1'b1;
         end
         default: ;
      endcase
   end

   imm_fit_check u_imm_fit_check (
      .imm_i    (in_imm_i),
      .width_i  (imm_w),
      .signed_i (imm_signed),
      .fits_o   (imm_fits),
      .field_o  (imm_field)
   );

   always_comb begin
      enc_word = '0;
      unique case (cls)
         ClsCompute:  enc_word = {in_opcode_i, in_ra_i, in_rb_i,
                                  in_use_imm_i ? imm_field[3:0] : in_rc_i};
         ClsMemory:   enc_word = {in_opcode_i, in_ra_i, in_rb_i, imm_field[3:0]};
         ClsLoadByte: enc_word = {in_opcode_i, in_ra_i, imm_field[7:0]};
         ClsControl:  enc_word = {in_opcode_i, in_cond_i, imm_field[8:0]};
         default: ;
      endcase
   end

   assign hs         = out_valid_q & out_ready_i;
   assign in_ready_o = (state_q == StLoad) && (!out_valid_q || out_ready_i)
                       && (acc_q < DepthCnt);
   assign accept     = in_valid_i & in_ready_o;

`ifdef IMM_RANGE_CHECK_EN
   assign reject = accept & check_en & ~imm_fits;
`else
   assign reject = 1'b0;
   logic unused_check;
   assign unused_check = imm_fits ^ check_en;
`endif

   assign wr_accept = accept & ~reject;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      count_d     = count_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d    = StLoad;
               addr_d     = BaseAddr;
               count_d    = '0;
               acc_d      = '0;
               err_code_d = 2'b00;
            end
         end
         StLoad: begin
            if (hs) begin
               addr_d      = addr_q + 1'b1;
               count_d     = count_q + 1'b1;
               out_valid_d = 1'b0;
               if ((count_q + 1'b1) == DepthCnt) begin
                  state_d = StDone;
               end
            end
            // A same-cycle accept reloads the register behind the handshake
            if (wr_accept) begin
               out_valid_d = 1'b1;
               out_data_d  = enc_word;
               out_addr_d  = hs ? addr_q + 1'b1 : addr_q;
               acc_d       = acc_q + 1'b1;
            end
            if (reject) begin
               err_d      = 1'b1;
               err_code_d = class_err_code(cls);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         addr_q      <= BaseAddr;
         count_q     <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_addr_o  = out_addr_q;
   assign busy_o      = (state_q == StLoad);
   assign done_o      = (state_q == StDone);
   assign err_o       = err_q;
   assign err_code_o  = err_code_q;
   assign count_o     = count_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate-extension path: accepts decoded instruction fields and packs them into 16-bit instruction words.
- Narrows the 16-bit immediate to the field width of its class, with range checking.
- Streams accepted words, with sequential addresses, into an instruction-memory write port.
- Sits between the testbench/boot loader and instruction memory; used to load programs before the core leaves reset.

Parameters:
- ADDR_W, 8, width of the instruction-memory word address.
- DEPTH, 256, maximum words per load session (1..2^ADDR_W).
- BASE_ADDR, 0, address of the first word written in each session.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin load session; honoured only in IDLE or DONE
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle
- in_opcode  in  4  instruction[15:12]
- in_ra  in  4  instruction[11:8]: rd/rt
- in_rb  in  4  instruction[7:4]: rs
- in_rc  in  4  instruction[3:0] for register-register compute
- in_cond  in  3  branch condition, instruction[11:9]
- in_imm  in  16  signed/unsigned immediate, full width
- in_use_imm  in  1  compute class only: [3:0] takes imm, not rc
- out_valid  out  1  write word valid
- out_ready  in  1  memory accepts the word
- out_addr  out  ADDR_W  write address
- out_data  out  16  encoded instruction
- busy  out  1  state == LOAD
- done  out  1  state == DONE
- err  out  1  one-cycle pulse on a rejected bundle
- err_code  out  2  class of last rejected bundle; holds until next error
- count  out  ADDR_W+1  words written this session

Behaviour:
- Reset values: all outputs 0, state IDLE, internal address BASE_ADDR.
- States:
  - IDLE --start--> LOAD, which clears count and err_code and sets the address to BASE_ADDR.
  - LOAD --(count reaches DEPTH, on the final out handshake)--> DONE.
  - DONE --start--> LOAD.
  - start while in LOAD is ignored.
- in_ready = (state==LOAD) && (!out_valid || out_ready) && (accepted words < DEPTH). Rejected bundles do not count as accepted.
- Accept happens when in_valid && in_ready. Encoding is by opcode class:
  - 0xxx compute: {op, ra, rb, use_imm ? imm[3:0] : rc}. Immediate range is unsigned 0..15.
  - 100x memory: {op, ra, rb, imm[3:0]}. Range is signed -8..7.
  - 101x load-byte: {op, ra, imm[7:0]}. Range is signed -128..127.
  - 11xx control: {op, cond, imm[8:0]}. Range is signed -256..255.
- Range checks:
  - Signed: imm bits above the field width all equal the field MSB.
  - Unsigned: imm[15:4] == 0.
  - Register-register compute (use_imm=0) skips the check.
- Latency: a valid accepted word is registered in 1 cycle. out_valid rises the cycle after acceptance.
- Output register:
  - out_data/out_addr hold stable while out_valid && !out_ready.
  - On an out handshake: address +1, count +1.
  - A new accept in the same cycle as the handshake reloads the register with no bubble.
- Address wraps mod 2^ADDR_W. Writes beyond DEPTH are impossible because of the in_ready gating.
- Rejected bundle: consumed (in_ready handshake completes), err pulses in the cycle after acceptance, err_code = opcode[15:14] class code (00 compute, 10 memory, 11 control), no write.
- Reset mid-session: returns to IDLE immediately and drops any pending output word.

Optional Feature:
- IMM_RANGE_CHECK_EN defined: range checking and rejection as above.
- Undefined: no rejection. The immediate is silently truncated to the field width, err is tied to 0, and err_code to 0.

Decomposition:
- Shared package isa_pkg:
  - opcode class patterns
  - field bit positions
  - immediate widths (4/4/8/9)
  - err_code constants
  - instruction width 16
- Natural sub-module imm_fit_check: combinational; takes imm, width, signedness; returns fits and the truncated field.
- FSM, output register and counters stay in the top.

Test Plan:
- start; ADD op=0000 ra=1 rb=2 rc=3 use_imm=0 -> out_data=0x0123, out_addr=0, one cycle after accept.
- SLL op=0100 ra=4 rb=4 imm=5 use_imm=1; then LW op=1000 ra=2 rb=3 imm=-2 -> 0x4445 @0, then 0x823E @1.
- LLB op=1010 ra=5 imm=0xFF80 -> 0xA580. Branch op=1100 cond=3 imm=-1 -> 0xC7FF.
- With IMM_RANGE_CHECK_EN: LW imm=8 -> err pulse, err_code=10, no write, count unchanged, next word goes to the same address.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready low, out_data/out_addr stable, no data loss on release.
- DEPTH=4: send 5 bundles -> 4 writes at 0..3, done=1, in_ready=0. Assert rst mid-session -> all outputs 0, IDLE.
